// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_port_arbiter
// Purpose  : Round-robin sharing of one memory port among NUM_PORTS masters,
//            one transaction outstanding, with a response timeout per grant.
// Revision : 1.0 - initial release
// ============================================================================
module memory_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             client_memory_enable,
  input  logic [NUM_PORTS-1:0]             client_memory_command,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  client_read_memory_address,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  client_write_memory_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  client_write_memory_data,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  client_write_memory_mask,
  output logic [NUM_PORTS-1:0]             client_memory_ready,
  output logic [NUM_PORTS-1:0]             client_memory_valid,
  output logic [DATA_WIDTH-1:0]            client_read_memory_data,
  output logic [NUM_PORTS-1:0]             client_memory_error,
  input  logic                             memory_ready,
  input  logic                             memory_valid,
  input  logic [DATA_WIDTH-1:0]            read_memory_data,
  output logic [ADDR_WIDTH-1:0]            read_memory_address,
  output logic [ADDR_WIDTH-1:0]            write_memory_address,
  output logic [DATA_WIDTH-1:0]            write_memory_data,
  output logic [DATA_WIDTH-1:0]            write_memory_mask,
  output logic                             memory_command,
  output logic                             memory_enable,
  output logic [GW-1:0]                    debug_grant
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           r_state;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        r_last_grant;
  logic [CW-1:0]        r_count;

  logic [GW-1:0]        w_winner;
  int                   w_best;
  logic                 w_any_req;
  logic                 w_grant_req;
  logic                 w_accept;
  logic                 w_response;
  logic                 w_timeout;
  logic [NUM_PORTS-1:0] w_grant_oh;

  assign w_any_req = |client_memory_enable;

  // Rank each requester by its distance after last_grant; the nearest wins.
  always_comb begin
    w_winner = '0;
    w_best   = NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (client_memory_enable[i] &&
          (((i + NUM_PORTS - 1 - int'(r_last_grant)) % NUM_PORTS) < w_best)) begin
        w_best   = (i + NUM_PORTS - 1 - int'(r_last_grant)) % NUM_PORTS;
        w_winner = GW'(i);
      end
    end
  end

  always_comb begin
    w_grant_oh           = '0;
    w_grant_req          = 1'b0;
    read_memory_address  = '0;
    write_memory_address = '0;
    write_memory_data    = '0;
    write_memory_mask    = '0;
    memory_command       = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == GW'(i)) begin
        w_grant_oh[i]        = 1'b1;
        w_grant_req          = client_memory_enable[i];
        read_memory_address  = client_read_memory_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        write_memory_address = client_write_memory_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        write_memory_data    = client_write_memory_data[i*DATA_WIDTH +: DATA_WIDTH];
        write_memory_mask    = client_write_memory_mask[i*DATA_WIDTH +: DATA_WIDTH];
        memory_command       = client_memory_command[i];
      end
    end
  end

  // Pulses are suppressed while reset is high so an abandoned transfer never reports.
  assign memory_enable = !reset && (r_state == S_ISSUE) && w_grant_req;
  assign w_accept      = memory_enable && memory_ready;
  assign w_response    = !reset && (r_state == S_WAIT) && memory_valid;
  assign w_timeout     = !reset && (r_state == S_WAIT) && !memory_valid &&
                         (TIMEOUT_CYCLES != 0) && (r_count == CW'(TIMEOUT_CYCLES - 1));

  assign client_memory_ready     = w_accept   ? w_grant_oh : '0;
  assign client_memory_valid     = w_response ? w_grant_oh : '0;
  assign client_memory_error     = w_timeout  ? w_grant_oh : '0;
  assign client_read_memory_data = read_memory_data;
  assign debug_grant             = r_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_PORTS - 1);
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_ISSUE;
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        S_ISSUE: begin
          if (!w_grant_req) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_state <= S_WAIT;
            r_count <= '0;
          end
        end
        S_WAIT: begin
          if (w_response || w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Round-robin arbiter that lets NUM_PORTS requesters (cores, instruction fetch, debug or DMA masters) share the single memory port. Each client side exposes the same enable/command/ready/valid handshake and address/data/mask fields as a core's memory port. The block is parametrised in port count and data/address width. It adds fair arbitration, per-port response routing and a response timeout with a per-port error pulse. It sits between the masters and the memory/bus controller, with exactly one transaction outstanding at a time.

## Interface
- NUM_PORTS, 2, number of client ports (≥1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; masks are bit masks of the same width
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before an error is raised; 0 disables the timeout
- GW (localparam), max(1, clog2(NUM_PORTS)), grant index width

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- client_memory_enable  in  NUM_PORTS  request valid, per port
- client_memory_command  in  NUM_PORTS  0 = read, 1 = write
- client_read_memory_address  in  NUM_PORTS*ADDR_WIDTH  packed; port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- client_write_memory_address  in  NUM_PORTS*ADDR_WIDTH  packed, same layout
- client_write_memory_data  in  NUM_PORTS*DATA_WIDTH  packed
- client_write_memory_mask  in  NUM_PORTS*DATA_WIDTH  packed
- client_memory_ready  out  NUM_PORTS  acceptance pulse for the granted port
- client_memory_valid  out  NUM_PORTS  response pulse for the granted port
- client_read_memory_data  out  DATA_WIDTH  broadcast copy of read_memory_data
- client_memory_error  out  NUM_PORTS  timeout pulse for the granted port
- memory_ready  in  1  downstream can accept a request
- memory_valid  in  1  downstream response; read data valid or write done
- read_memory_data  in  DATA_WIDTH  downstream read data
- read_memory_address, write_memory_address  out  ADDR_WIDTH  muxed from the granted port
- write_memory_data, write_memory_mask  out  DATA_WIDTH  muxed from the granted port
- memory_command  out  1  muxed from the granted port
- memory_enable  out  1  downstream request
- debug_grant  out  GW  current grant index

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE to ISSUE when any client_memory_enable bit is set:
  - Winner is the first requesting port scanning from last_grant+1 upward, wrapping modulo NUM_PORTS.
  - On the transition, register grant = winner and last_grant = winner.
- ISSUE:
  - memory_enable = client_memory_enable[grant].
  - The address, data, mask and command outputs are muxed combinationally from port grant.
  - Acceptance occurs when memory_enable && memory_ready. That cycle, client_memory_ready[grant] = 1 and the state goes to WAIT.
  - If client_memory_enable[grant] drops before acceptance, return to IDLE with no transaction issued.
- WAIT:
  - memory_enable = 0.
  - When memory_valid = 1: client_memory_valid[grant] = 1 in the same cycle and the state goes to IDLE.
  - The timeout counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES (≠0) with no memory_valid, pulse client_memory_error[grant] for 1 cycle, assert no valid, and go to IDLE.
  - If memory_valid and the timeout coincide, the valid wins and no error is raised.
- memory_valid outside WAIT is ignored; a late response after a timeout is dropped.
- client_read_memory_data always equals read_memory_data. Clients qualify it with their own valid bit.
- Outputs that are only meaningful in ISSUE (address/data/mask/command) still follow port grant in the other states. Downstream qualifies them with memory_enable.
- All client_memory_ready, client_memory_valid and client_memory_error bits other than [grant] are 0 in every state.
- Clients hold their request fields stable from assertion until they see client_memory_ready.

## Timing
- Reset values:
  - state = IDLE, grant = 0, last_grant = NUM_PORTS-1 (so port 0 wins first), counter = 0.
  - memory_enable, all client ready/valid/error bits and debug_grant are 0.
- Reset has priority in every state. A transaction in flight is abandoned, memory_enable is 0 in the cycle after reset is asserted, and no client pulse is issued.
- Request sampled in IDLE at cycle t:
  - memory_enable is high from t+1.
  - With memory_ready already high, acceptance happens at t+1.
- A response at cycle v returns the state to IDLE at v+1. A pending request is then re-arbitrated at v+1 and issued at v+2.
- Minimum round trip: 3 cycles (request, accept, response).
- Peak throughput: one transaction per 3 cycles.
- Counter behaviour:
  - Clears on entry to WAIT.
  - Error pulses at WAIT cycle TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after acceptance.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- NUM_PORTS = 1: grant is constantly 0 and behaviour otherwise matches the multi-port case.

## Test plan
- Single read: port 0 reads 0x100; memory_ready = 1; memory_valid returned 2 cycles after accept with 0xDEADBEEF -> read_memory_address = 0x100, client_memory_ready[0] pulses at t+1, client_memory_valid[0] pulses together with data 0xDEADBEEF, no other port bits set.
- Fairness: NUM_PORTS = 4 with all ports continuously requesting, responses 1 cycle after accept -> grant order 0,1,2,3,0,1; debug_grant follows; each port gets exactly 1 response per 4 transactions.
- Backpressure: memory_ready low for 5 cycles in ISSUE, and port 2 write with mask 0x0000FFFF and data 0x1234 -> memory_enable held 5 cycles with stable fields, one ready pulse, write response routed to port 2 only.
- Timeout: TIMEOUT_CYCLES = 8, no memory_valid -> client_memory_error[grant] pulses 8 cycles after accept, state IDLE; a memory_valid at cycle 12 produces no client_memory_valid.
- Withdraw and reset: granted port drops enable in ISSUE -> IDLE with no accept. Reset asserted in WAIT -> next cycle all outputs 0, last_grant = NUM_PORTS-1, and a subsequent response is ignored.
